// File: rtl/uart_tx_ctrl.sv
// UART transmitter: serializes one byte per accepted DATA_VALID as
// start / 8 data (LSB first) / optional parity / stop, each bit held
// Prescale clk cycles. TX_OUT and Busy are registered.
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PRSC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [PRSC_W-1:0] Prescale,
  output logic              TX_OUT,
  output logic              Busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PRSC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [PRSC_W-1:0]   prsc_q, prsc_d;
  logic                par_en_q, par_en_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                bit_done;
  logic                last_bit;

  // Request is only honoured while idle; anything during a frame is dropped.
  assign accept   = (state_q == S_IDLE) && DATA_VALID;
  // Bit boundary; a latched Prescale of 0 wraps the compare to 63 (64 cycles/bit).
  assign bit_done = (edge_cnt_q == PRSC_W'(prsc_q - PRSC_W'(1)));
  assign last_bit = (bit_cnt_q == LAST_BIT);

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: frame capture, bit timing and shifting.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    prsc_d     = prsc_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (accept) begin
          shreg_d  = P_DATA;
          prsc_d   = Prescale;
          par_en_d = PAR_EN;
          parity_d = (^P_DATA) ^ PAR_TYP;
        end
      end
      S_START, S_PARITY, S_STOP: begin
        edge_cnt_d = bit_done ? '0 : PRSC_W'(edge_cnt_q + PRSC_W'(1));
      end
      S_DATA: begin
        edge_cnt_d = bit_done ? '0 : PRSC_W'(edge_cnt_q + PRSC_W'(1));
        if (bit_done) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = last_bit ? '0 : CNT_W'(bit_cnt_q + CNT_W'(1));
        end
      end
      default: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so TX_OUT/Busy register in step with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        tx_d   = shreg_d[0];
        busy_d = 1'b1;
      end
      S_PARITY: begin
        tx_d   = parity_d;
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      prsc_q     <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      prsc_q     <= prsc_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-timeline reference model checked every
// cycle, directed frames with literal expectations, then random traffic.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fails  = 0;
  logic chk_on = 1'b0;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held for len cycles.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pe,
                                             input logic pt);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (pe) b[9] = (^d) ^ pt;
    return b;
  endfunction

  logic        m_busy;
  int          m_cnt;
  int          m_len;
  int          m_nbits;
  logic [10:0] m_bits;
  logic        exp_tx;
  logic        exp_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_len   <= 8;
      m_nbits <= 10;
      m_bits  <= '1;
    end else if (!m_busy) begin
      if (DATA_VALID) begin
        m_busy  <= 1'b1;
        m_cnt   <= 0;
        m_len   <= (Prescale == 6'd0) ? 64 : int'(Prescale);
        m_nbits <= PAR_EN ? 11 : 10;
        m_bits  <= frame_bits(P_DATA, PAR_EN, PAR_TYP);
      end
    end else if (m_cnt == m_nbits * m_len - 1) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always_comb begin
    exp_busy = m_busy;
    exp_tx   = m_busy ? m_bits[4'(m_cnt / m_len)] : 1'b1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_line", int'(TX_OUT), int'(exp_tx));
      chk("busy", int'(Busy), int'(exp_busy));
    end
  end

  // Frame recorder: line levels of each completed busy run, and idle gap before it.
  logic last_frame[$];
  logic cur_frame[$];
  int   frames_done = 0;
  int   gap_cnt = 0;
  int   last_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_frame.delete();
      gap_cnt = 0;
    end else if (Busy) begin
      if (cur_frame.size() == 0) last_gap = gap_cnt;
      cur_frame.push_back(TX_OUT);
    end else begin
      if (cur_frame.size() != 0) begin
        last_frame = cur_frame;
        cur_frame.delete();
        frames_done++;
        gap_cnt = 0;
      end
      gap_cnt++;
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps);
    @(negedge clk); #1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    DATA_VALID = 1'b1;
    @(negedge clk); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_frame(input int prev, input int limit);
    int n;
    n = 0;
    while (frames_done == prev && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_done_in_time", (frames_done > prev) ? 1 : 0, 1);
  endtask

  task automatic check_frame(input string name, input int nb, input int len,
                             input int e[11]);
    chk({name, "_busy_len"}, last_frame.size(), nb * len);
    for (int k = 0; k < nb; k++) begin
      if (k * len + len / 2 < last_frame.size())
        chk($sformatf("%s_bit%0d", name, k), int'(last_frame[k * len + len / 2]), e[k]);
      else
        chk($sformatf("%s_bit%0d_missing", name, k), 0, 1);
    end
  endtask

  initial begin
    int prev;
    int lows;
    int e_a5_even[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int e_a5_odd[11]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    int e_00[11]      = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int e_3c[11]      = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int e_55[11]      = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    int e_aa[11]      = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    int e_81[11]      = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    rst_n      = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_tx", int'(TX_OUT), 1);
    chk("reset_busy", int'(Busy), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_tx", int'(TX_OUT), 1);
    chk("idle_busy", int'(Busy), 0);

    // 0xA5, even parity, 8 clk/bit.
    prev = frames_done;
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    wait_frame(prev, 200);
    check_frame("a5_even", 11, 8, e_a5_even);

    // 0xA5, odd parity.
    repeat (2) @(negedge clk);
    prev = frames_done;
    send(8'hA5, 1'b1, 1'b1, 6'd8);
    wait_frame(prev, 200);
    check_frame("a5_odd", 11, 8, e_a5_odd);

    // 0x00 without parity, 16 clk/bit: 144 low cycles then stop.
    prev = frames_done;
    send(8'h00, 1'b0, 1'b0, 6'd16);
    wait_frame(prev, 300);
    check_frame("zero", 10, 16, e_00);
    lows = 0;
    foreach (last_frame[i]) if (last_frame[i] == 1'b0) lows++;
    chk("zero_low_cycles", lows, 144);

    // 0x3C with a competing request and config changes mid-frame.
    prev = frames_done;
    send(8'h3C, 1'b1, 1'b0, 6'd16);
    repeat (30) @(negedge clk);
    #1;
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    Prescale   = 6'd8;
    DATA_VALID = 1'b1;
    @(negedge clk); #1;
    DATA_VALID = 1'b0;
    wait_frame(prev, 400);
    check_frame("ignore_3c", 11, 16, e_3c);
    repeat (200) @(negedge clk);
    #1;
    chk("ignore_no_extra_frame", frames_done, prev + 1);
    chk("ignore_idle_busy", int'(Busy), 0);

    // Back-to-back with DATA_VALID held high.
    prev = frames_done;
    @(negedge clk); #1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd32;
    DATA_VALID = 1'b1;
    @(negedge clk); #1;
    P_DATA = 8'hAA;
    wait_frame(prev, 400);
    check_frame("b2b_55", 10, 32, e_55);
    @(negedge clk); #1;
    chk("b2b_second_started", int'(Busy), 1);
    DATA_VALID = 1'b0;
    wait_frame(prev + 1, 400);
    check_frame("b2b_aa", 10, 32, e_aa);
    chk("b2b_idle_gap", last_gap, 1);

    // Reset during data bit 4 of 0xC3 (bit 4 is 0), then a clean 0x81 frame.
    repeat (3) @(negedge clk);
    send(8'hC3, 1'b0, 1'b0, 6'd8);
    repeat (42) @(negedge clk);
    #1;
    chk("pre_reset_bit4_low", int'(TX_OUT), 0);
    chk("pre_reset_busy", int'(Busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_tx", int'(TX_OUT), 1);
    chk("mid_reset_busy", int'(Busy), 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    prev  = frames_done;
    send(8'h81, 1'b1, 1'b1, 6'd8);
    wait_frame(prev, 200);
    check_frame("after_reset_81", 11, 8, e_81);

    // Random traffic: requests and config churn on any cycle.
    prev = frames_done;
    for (int c = 0; c < 9000; c++) begin
      int r;
      @(negedge clk); #1;
      DATA_VALID = ($urandom_range(0, 2) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3)       Prescale = 6'd8;
      else if (r < 6)  Prescale = 6'd16;
      else if (r < 8)  Prescale = 6'd32;
      else if (r == 8) Prescale = 6'd0;
      else             Prescale = 6'($urandom_range(1, 63));
    end
    DATA_VALID = 1'b0;
    begin
      int n;
      n = 0;
      while (Busy && n < 1000) begin
        @(negedge clk); #1;
        n++;
      end
    end
    chk("random_drained", int'(Busy), 0);
    chk("random_frames_seen", (frames_done - prev >= 10) ? 1 : 0, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
